// File: rtl/phase_pkg.sv
// Shared types for the sequencer phase code and the monitor FSM.
package phase_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        ACQ,
        LOCKED,
        FAULT
    } mon_state_t;

    localparam logic [1:0] PHASE_ILLEGAL = 2'b11;

    // The successor of the illegal code has no meaning; S0 is returned so the function is total.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            S0:      return S1;
            S1:      return S2;
            S2:      return S0;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/phase_monitor.sv
// Passive checker for the S0->S1->S2 phase stream: lock acquisition,
// round counting and sticky error capture.
module phase_monitor
    import phase_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int ERR_W    = 8,
    parameter int LOCK_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       phase_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             round_pulse,
    output logic [CNT_W-1:0] round_count,
    output logic             err_code,
    output logic             err_step,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       expected
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

    mon_state_t       r_state, w_state_next;
    logic [1:0]       r_prev, w_prev_next;
    logic             r_have_prev, w_have_prev_next;
    logic [3:0]       r_run, w_run_next;
    logic             r_pulse, w_pulse_next;
    logic [CNT_W-1:0] r_round_count, w_round_count_next;
    logic             r_err_code, w_err_code_next;
    logic             r_err_step, w_err_step_next;
    logic             w_err_inc;

    logic [1:0]       w_succ;
    logic             w_legal;
    logic             w_illegal;
    logic             w_bad;

    assign w_succ    = 2'(next_phase(phase_t'(r_prev)));
    // A stored illegal code has no successor, so the sample after it can never be legal.
    assign w_legal   = r_have_prev && (r_prev != PHASE_ILLEGAL) && (phase_in == w_succ);
    assign w_illegal = (phase_in == PHASE_ILLEGAL);
    assign w_bad     = r_have_prev && !w_legal && !w_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ACQ;
            r_prev        <= 2'd0;
            r_have_prev   <= 1'b0;
            r_run         <= 4'd0;
            r_pulse       <= 1'b0;
            r_round_count <= '0;
            r_err_code    <= 1'b0;
            r_err_step    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_prev        <= w_prev_next;
            r_have_prev   <= w_have_prev_next;
            r_run         <= w_run_next;
            r_pulse       <= w_pulse_next;
            r_round_count <= w_round_count_next;
            r_err_code    <= w_err_code_next;
            r_err_step    <= w_err_step_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_prev_next        = r_prev;
        w_have_prev_next   = r_have_prev;
        w_run_next         = r_run;
        w_pulse_next       = 1'b0;
        w_round_count_next = r_round_count;
        w_err_code_next    = r_err_code;
        w_err_step_next    = r_err_step;
        w_err_inc          = 1'b0;

        // Clear is applied first so that an error in the same cycle overrides it.
        if (clr_err) begin
            w_err_code_next = 1'b0;
            w_err_step_next = 1'b0;
            if (r_state == FAULT) begin
                w_state_next = ACQ;
                w_run_next   = 4'd0;
            end
        end

        if (en) begin
            w_prev_next      = phase_in;
            w_have_prev_next = 1'b1;
            unique case (r_state)
                ACQ: begin
                    if (w_legal) begin
                        if (r_run + 4'd1 == LOCK_RUN) begin
                            w_state_next = LOCKED;
                            w_run_next   = 4'd0;
                        end else begin
                            w_run_next = r_run + 4'd1;
                        end
                    end else if (w_illegal || w_bad) begin
                        w_run_next = 4'd0;
                    end
                end
                LOCKED: begin
                    if (w_legal) begin
                        if (phase_in == S0) begin
                            w_pulse_next       = 1'b1;
                            w_round_count_next = r_round_count + 1'b1;
                        end
                    end else if (w_illegal) begin
                        w_err_code_next = 1'b1;
                        w_err_inc       = 1'b1;
                        w_state_next    = FAULT;
                    end else if (w_bad) begin
                        w_err_step_next = 1'b1;
                        w_err_inc       = 1'b1;
                        w_state_next    = FAULT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_count (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_err_inc),
        .clr  (1'b0),
        .count(err_count)
    );

    assign locked      = (r_state == LOCKED);
    assign round_pulse = r_pulse;
    assign round_count = r_round_count;
    assign err_code    = r_err_code;
    assign err_step    = r_err_step;
    assign expected    = r_have_prev ? w_succ : 2'd0;

endmodule

// File: tb/tb_phase_monitor.sv
// Scoreboard bench for phase_monitor: the driver queues hand-derived expectations
// per sample, the monitor pops and compares one entry per response.
module tb_phase_monitor;

    localparam int CNT_W = 4;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       phase_in;
    logic             clr_err;
    logic             locked;
    logic             round_pulse;
    logic [CNT_W-1:0] round_count;
    logic             err_code;
    logic             err_step;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       expected;

    phase_monitor #(
        .CNT_W   (CNT_W),
        .ERR_W   (ERR_W),
        .LOCK_LEN(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .phase_in   (phase_in),
        .clr_err    (clr_err),
        .locked     (locked),
        .round_pulse(round_pulse),
        .round_count(round_count),
        .err_code   (err_code),
        .err_step   (err_step),
        .err_count  (err_count),
        .expected   (expected)
    );

    typedef struct {
        string nm;
        int    lock;
        int    pulse;
        int    ec;
        int    es;
        int    rc;
        int    cnt;
        int    exph;   // -1: expected output not checked (successor of illegal code)
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_rc = 0;
    int   exp_cnt = 0;
    event imm_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, req);
        end
    endtask

    // Monitor: one response per clock (or per immediate-check event).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or imm_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "locked", int'(locked), e.lock);
                chk(e.nm, "round_pulse", int'(round_pulse), e.pulse);
                chk(e.nm, "err_code", int'(err_code), e.ec);
                chk(e.nm, "err_step", int'(err_step), e.es);
                chk(e.nm, "round_count", int'(round_count), e.rc);
                chk(e.nm, "err_count", int'(err_count), e.cnt);
                if (e.exph >= 0) chk(e.nm, "expected", int'(expected), e.exph);
                $display("txn %-10s en=%0b ph=%0d clr=%0b -> lk=%0b rp=%0b rc=%0d ec=%0b es=%0b cnt=%0d exp=%0d",
                         e.nm, en, phase_in, clr_err, locked, round_pulse, round_count,
                         err_code, err_step, err_count, expected);
            end
        end
    end

    task automatic step(input string nm, input logic e, input logic [1:0] p, input logic c,
                        input int lk, input int pu, input int ec, input int es, input int ex);
        exp_t x;
        @(negedge clk);
        en       = e;
        phase_in = p;
        clr_err  = c;
        x.nm = nm; x.lock = lk; x.pulse = pu; x.ec = ec; x.es = es;
        x.rc = exp_rc; x.cnt = exp_cnt; x.exph = ex;
        q.push_back(x);
    endtask

    // Raise reset between edges and check the outputs before any clock edge.
    task automatic reset_check(input string nm);
        exp_t x;
        @(negedge clk);
        rst     = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
        exp_rc  = 0;
        exp_cnt = 0;
        #1;
        x.nm = nm; x.lock = 0; x.pulse = 0; x.ec = 0; x.es = 0;
        x.rc = 0; x.cnt = 0; x.exph = 0;
        q.push_back(x);
        -> imm_ev;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; phase_in = 2'd0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step("rst_idle", 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Clean acquisition and first round
        step("seed",  1, 2'd0, 0, 0, 0, 0, 0, 1);
        step("acq1",  1, 2'd1, 0, 0, 0, 0, 0, 2);
        step("acq2",  1, 2'd2, 0, 0, 0, 0, 0, 0);
        step("lock",  1, 2'd0, 0, 1, 0, 0, 0, 1);
        step("lk_s1", 1, 2'd1, 0, 1, 0, 0, 0, 2);
        step("lk_s2", 1, 2'd2, 0, 1, 0, 0, 0, 0);
        exp_rc = 1;
        step("round1", 1, 2'd0, 0, 1, 1, 0, 0, 1);

        // Repeated phase -> bad step, FAULT holds counts
        step("pre_bad", 1, 2'd1, 0, 1, 0, 0, 0, 2);
        exp_cnt = 1;
        step("bad_s1",  1, 2'd1, 0, 0, 0, 0, 1, 2);
        step("flt_s2",  1, 2'd2, 0, 0, 0, 0, 1, 0);
        step("flt_s0",  1, 2'd0, 0, 0, 0, 0, 1, 1);
        step("clr1",    0, 2'd3, 1, 0, 0, 0, 0, 1);
        step("racq1",   1, 2'd1, 0, 0, 0, 0, 0, 2);
        step("racq2",   1, 2'd2, 0, 0, 0, 0, 0, 0);
        step("relock",  1, 2'd0, 0, 1, 0, 0, 0, 1);

        // Illegal code, then clear and relock
        step("pre_ill", 1, 2'd1, 0, 1, 0, 0, 0, 2);
        exp_cnt = 2;
        step("ill3",    1, 2'd3, 0, 0, 0, 1, 0, -1);
        step("flt_aft", 1, 2'd2, 0, 0, 0, 1, 0, 0);
        step("clr2",    0, 2'd1, 1, 0, 0, 0, 0, 0);
        step("racq3",   1, 2'd0, 0, 0, 0, 0, 0, 1);
        step("racq4",   1, 2'd1, 0, 0, 0, 0, 0, 2);
        step("relock2", 1, 2'd2, 0, 1, 0, 0, 0, 0);

        // Enable low mid-round
        exp_rc = 2;
        step("round2", 1, 2'd0, 0, 1, 1, 0, 0, 1);
        step("mid_s1", 1, 2'd1, 0, 1, 0, 0, 0, 2);
        for (int i = 0; i < 5; i++)
            step("en_lo", 0, (i % 2 == 0) ? 2'd3 : 2'd0, 0, 1, 0, 0, 0, 2);
        step("res_s2", 1, 2'd2, 0, 1, 0, 0, 0, 0);
        exp_rc = 3;
        step("round3", 1, 2'd0, 0, 1, 1, 0, 0, 1);
        step("pulse_off", 0, 2'd1, 0, 1, 0, 0, 0, 1);

        // Error and clear together: error wins; then async reset in FAULT
        exp_cnt = 3;
        step("err_clr", 1, 2'd0, 1, 0, 0, 0, 1, 1);
        step("flt_hold", 1, 2'd1, 0, 0, 0, 0, 1, 2);
        reset_check("rst_flt");
        step("post_rst", 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Round counter wrap: 17 rounds with CNT_W=4
        step("w_seed", 1, 2'd0, 0, 0, 0, 0, 0, 1);
        step("w_acq1", 1, 2'd1, 0, 0, 0, 0, 0, 2);
        step("w_acq2", 1, 2'd2, 0, 0, 0, 0, 0, 0);
        step("w_lock", 1, 2'd0, 0, 1, 0, 0, 0, 1);
        for (int r = 0; r < 17; r++) begin
            step("w_s1", 1, 2'd1, 0, 1, 0, 0, 0, 2);
            step("w_s2", 1, 2'd2, 0, 1, 0, 0, 0, 0);
            exp_rc = (exp_rc + 1) % 16;
            step("w_s0", 1, 2'd0, 0, 1, 1, 0, 0, 1);
        end

        // 300 fault/clear cycles: error counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            if (exp_cnt < 255) exp_cnt++;
            step("sat_bad", 1, 2'd0, 0, 0, 0, 0, 1, 1);
            step("sat_clr", 0, 2'd0, 1, 0, 0, 0, 0, 1);
            step("sat_a1",  1, 2'd1, 0, 0, 0, 0, 0, 2);
            step("sat_a2",  1, 2'd2, 0, 0, 0, 0, 0, 0);
            step("sat_lk",  1, 2'd0, 0, 1, 0, 0, 0, 1);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
